// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, address field sizes and the arbiter
// state encoding for the dcache sharing logic.
package dcache_pkg;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 3;
   localparam int IDX_W  = 10;
   localparam int OFF_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker. On a tie the port that did not
// win last time is chosen; the last-grant register moves on upd.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic en,
   input  logic upd,
   input  logic upd_id,
   output logic gnt0,
   output logic gnt1
);

   logic last;
   logic pick1;

   // port 1 wins when alone, or on a tie when port 0 went last
   always_comb begin
      pick1 = req1 & (~req0 | ~last);
   end

   assign gnt1 = en & pick1;
   assign gnt0 = en & req0 & ~pick1;

   // last-grant pointer; reset to 1 so port 0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= 1'b1;
      end else if (upd) begin
         last <= upd_id;
      end
   end

endmodule

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: shares one direct-mapped dcache between two ports,
// sequencing enable windows, read latency and done pulses.
module dcache_arbiter
   import dcache_pkg::*;
#(
   parameter int ADDR_W = dcache_pkg::ADDR_W,
   parameter int DATA_W = dcache_pkg::DATA_W,
   parameter int EN_CYC = 2,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] c_r_addr,
   output logic [ADDR_W-1:0] c_w_addr,
   output logic [DATA_W-1:0] c_w_data,
   output logic              c_r_enable,
   output logic              c_w_enable,
   input  logic [DATA_W-1:0] c_r_data
);

   localparam logic [7:0] EN_LAST = 8'(EN_CYC - 1);
   localparam logic [7:0] RD_LAST = 8'((RD_LAT > 0) ? RD_LAT - 1 : 0);

   state_t            state;
   logic [7:0]        cnt;
   logic              l_we;
   logic              l_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .req1   (req1),
      .en     (state == S_IDLE),
      .upd    (state == S_DONE),
      .upd_id (l_id),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   // mux the winning port's request fields
   always_comb begin
      sel_we    = gnt1 ? we1    : we0;
      sel_addr  = gnt1 ? addr1  : addr0;
      sel_wdata = gnt1 ? wdata1 : wdata0;
   end

   // transaction sequencer with registered cache pins and done pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         l_we       <= 1'b0;
         l_id       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         c_r_addr   <= '0;
         c_w_addr   <= '0;
         c_w_data   <= '0;
         c_r_enable <= 1'b0;
         c_w_enable <= 1'b0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (gnt0 | gnt1) begin
                  l_we  <= sel_we;
                  l_id  <= gnt1;
                  cnt   <= '0;
                  state <= S_ISSUE;
                  if (sel_we) begin
                     c_w_addr   <= sel_addr;
                     c_w_data   <= sel_wdata;
                     c_w_enable <= 1'b1;
                  end else begin
                     c_r_addr   <= sel_addr;
                     c_r_enable <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (cnt == EN_LAST) begin
                  c_r_enable <= 1'b0;
                  c_w_enable <= 1'b0;
                  cnt        <= '0;
                  if (l_we || RD_LAT == 0) begin
                     if (!l_we) begin
                        if (l_id) rdata1 <= c_r_data;
                        else      rdata0 <= c_r_data;
                     end
                     done0 <= ~l_id;
                     done1 <= l_id;
                     state <= S_DONE;
                  end else begin
                     state <= S_WAIT;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_WAIT: begin
               if (cnt == RD_LAST) begin
                  if (l_id) rdata1 <= c_r_data;
                  else      rdata0 <= c_r_data;
                  done0 <= ~l_id;
                  done1 <= l_id;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter: directed scoreboard bench for dcache_arbiter,
// default timing plus an RD_LAT=0 / EN_CYC=1 instance.
module tb_dcache_arbiter;

   localparam int AW = 17;
   localparam int DW = 32;

   typedef struct {
      int          port;
      bit          rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, done0, done1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] c_r_addr, c_w_addr;
   logic [DW-1:0] c_w_data, c_r_data;
   logic          c_r_enable, c_w_enable;

   logic          b_req0, b_req1, b_we0, b_we1;
   logic [AW-1:0] b_addr0, b_addr1;
   logic [DW-1:0] b_wdata0, b_wdata1;
   logic          b_gnt0, b_gnt1, b_done0, b_done1;
   logic [DW-1:0] b_rdata0, b_rdata1;
   logic [AW-1:0] b_c_r_addr, b_c_w_addr;
   logic [DW-1:0] b_c_w_data, b_c_r_data;
   logic          b_c_r_enable, b_c_w_enable;

   logic [DW-1:0] mem   [0:(1<<AW)-1];
   logic [DW-1:0] mem_b [0:(1<<AW)-1];

   dcache_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1),
      .c_r_addr(c_r_addr), .c_w_addr(c_w_addr), .c_w_data(c_w_data),
      .c_r_enable(c_r_enable), .c_w_enable(c_w_enable),
      .c_r_data(c_r_data)
   );

   dcache_arbiter #(.EN_CYC(1), .RD_LAT(0)) dut_b (
      .clk(clk), .rst(rst),
      .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
      .addr0(b_addr0), .addr1(b_addr1),
      .wdata0(b_wdata0), .wdata1(b_wdata1),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
      .rdata0(b_rdata0), .rdata1(b_rdata1),
      .c_r_addr(b_c_r_addr), .c_w_addr(b_c_w_addr),
      .c_w_data(b_c_w_data),
      .c_r_enable(b_c_r_enable), .c_w_enable(b_c_w_enable),
      .c_r_data(b_c_r_data)
   );

   // cache models: one-cycle registered read for A, combinational for B
   always @(posedge clk) begin
      if (c_w_enable) mem[c_w_addr] = c_w_data;
      if (c_r_enable) c_r_data <= mem[c_r_addr];
      if (b_c_w_enable) mem_b[b_c_w_addr] = b_c_w_data;
   end
   assign b_c_r_data = mem_b[b_c_r_addr];

   int n_pass = 0;
   int n_chk  = 0;
   int n_fail = 0;
   int inv_a  = 0;
   int inv_b  = 0;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int p, input bit rd, input logic [31:0] d,
                       input int c);
      exp_t e;
      e.port = p;
      e.rd   = rd;
      e.data = d;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output int p, output int gc);
      p  = -1;
      gc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            p  = gnt1 ? 1 : 0;
            gc = cyc;
            break;
         end
      end
      if (p < 0) chk("gnt_timeout", 64'({gnt1, gnt0} != 2'b00), 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 40; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", sb.size(), 0);
      step();
   endtask

   task automatic b_txn(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] er);
      int gc;
      int dc;
      gc = -1;
      dc = -1;
      b_req0   = 1'b1;
      b_we0    = we;
      b_addr0  = a;
      b_wdata0 = d;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b_gnt0) begin
            gc = cyc;
            break;
         end
      end
      chk("b_gnt", b_gnt0, 1);
      step();
      b_req0 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b_done0) begin
            dc = cyc;
            break;
         end
      end
      chk("b_done_cyc", dc, gc + 2);
      if (!we) chk("b_rdata", b_rdata0, er);
      step();
   endtask

   // invariant watch on both instances
   always @(negedge clk) begin
      if (!rst) begin
         if ((c_r_enable && c_w_enable) || (gnt0 && gnt1) ||
             (done0 && done1)) inv_a++;
         if ((b_c_r_enable && b_c_w_enable) || (b_gnt0 && b_gnt1) ||
             (b_done0 && b_done1)) inv_b++;
      end
   end

   // scoreboard: every done must match the oldest expected transaction
   always @(negedge clk) begin
      if (!rst && (done0 || done1)) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {done1, done0}, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_port", done1, e.port);
            chk("done_cyc", cyc, e.cyc);
            if (e.rd) chk("rdata", e.port == 1 ? rdata1 : rdata0, e.data);
         end
      end
   end

   initial begin
      int p;
      int g;
      int g2;
      int ng;
      int ne;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
      b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
      mem[17'h00123] = 32'hA5A50123;

      repeat (2) step();
      @(negedge clk);
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_done", {done1, done0}, 0);
      chk("rst_en", {c_r_enable, c_w_enable}, 0);
      chk("rst_rdata", {rdata1, rdata0}, 0);
      chk("rst_caddr", {c_r_addr, c_w_addr}, 0);
      chk("rst_wdata", c_w_data, 0);
      step();
      rst = 1'b0;

      // reset abort during the first write enable cycle
      req0 = 1; we0 = 1; addr0 = 17'h00010; wdata0 = 32'h11111111;
      wait_gnt(p, g);
      chk("abort_gnt", p, 0);
      step();
      req0 = 0;
      chk("abort_wen", c_w_enable, 1);
      #2 rst = 1'b1;
      #1 chk("abort_wen_async", c_w_enable, 0);
      step();
      step();
      rst = 1'b0;

      // tie fairness: both held for four grants
      req0 = 1; we0 = 1; addr0 = 17'h00200; wdata0 = 32'h0000BEEF;
      req1 = 1; we1 = 0; addr1 = 17'h00123;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(p, g);
         chk("tie_order", p, i % 2);
         if (p == 1) push(1, 1, 32'hA5A50123, g + 4);
         else        push(0, 0, '0, g + 3);
         step();
         if (i == 3) begin
            req0 = 0;
            req1 = 0;
         end
      end
      drain();

      // write then read back through the other port
      req0 = 1; we0 = 1; addr0 = 17'h1380B; wdata0 = 32'h00000CCC;
      wait_gnt(p, g);
      chk("wr_gnt", p, 0);
      push(0, 0, '0, g + 3);
      step();
      req0 = 0;
      @(negedge clk);
      chk("wr_en1", {c_r_enable, c_w_enable}, 2'b01);
      chk("wr_addr", c_w_addr, 17'h1380B);
      chk("wr_data", c_w_data, 32'h00000CCC);
      step();
      @(negedge clk);
      chk("wr_en2", {c_r_enable, c_w_enable}, 2'b01);
      step();
      @(negedge clk);
      chk("wr_en3", {c_r_enable, c_w_enable}, 2'b00);
      step();
      req1 = 1; we1 = 0; addr1 = 17'h1380B;
      wait_gnt(p, g);
      chk("rd_gnt", p, 1);
      push(1, 1, 32'h00000CCC, g + 4);
      step();
      req1 = 0;
      @(negedge clk);
      chk("rd_en1", {c_r_enable, c_w_enable}, 2'b10);
      chk("rd_addr", c_r_addr, 17'h1380B);
      chk("w_addr_held", c_w_addr, 17'h1380B);
      step();
      @(negedge clk);
      chk("rd_en2", {c_r_enable, c_w_enable}, 2'b10);
      step();
      @(negedge clk);
      chk("rd_wait_en", {c_r_enable, c_w_enable}, 2'b00);
      chk("rd_wait_done", done1, 0);
      drain();
      chk("rdata1_held", rdata1, 32'h00000CCC);

      // request arriving while port 0 is in its wait window
      req0 = 1; we0 = 0; addr0 = 17'h00123;
      wait_gnt(p, g);
      chk("busy_first", p, 0);
      push(0, 1, 32'hA5A50123, g + 4);
      step();
      req0 = 0;
      step();
      step();
      req1 = 1; we1 = 0; addr1 = 17'h1380B;
      wait_gnt(p, g2);
      chk("busy_gnt", p, 1);
      chk("busy_gnt_cyc", g2, g + 5);
      push(1, 1, 32'h00000CCC, g2 + 4);
      step();
      req1 = 0;
      drain();

      // port 0 withdraws before the arbiter returns to idle
      req1 = 1; we1 = 1; addr1 = 17'h00300; wdata1 = 32'h00000300;
      wait_gnt(p, g);
      chk("wd_gnt", p, 1);
      push(1, 0, '0, g + 3);
      step();
      req1 = 0;
      req0 = 1; we0 = 1; addr0 = 17'h00777; wdata0 = 32'h00000777;
      step();
      req0 = 0;
      ng = 0;
      ne = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (gnt0 || gnt1) ng++;
         if (cyc >= g + 3 && (c_r_enable || c_w_enable)) ne++;
         step();
      end
      chk("wd_no_gnt", ng, 0);
      chk("wd_no_en", ne, 0);
      drain();

      // short timing instance
      b_txn(1'b1, 17'h0AAAA, 32'hDEADBEEF, '0);
      b_txn(1'b0, 17'h0AAAA, '0, 32'hDEADBEEF);
      b_txn(1'b1, 17'h1FFFF, 32'h12345678, '0);
      b_txn(1'b0, 17'h1FFFF, '0, 32'h12345678);

      chk("inv_a", inv_a, 0);
      chk("inv_b", inv_b, 0);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
